// File: rtl/rtc_pkg.sv
// Shared constants, set-field encodings and the 24h -> 12h hour mapping
// used by the timekeeping core.
package rtc_pkg;

    // Terminal values of each time field (binary, inclusive)
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    // Field selected for manual adjustment; SEL_NONE means normal timekeeping
    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_SEC  = 2'b01,
        SEL_MIN  = 2'b10,
        SEL_HR   = 2'b11
    } set_sel_e;

    // Map an internal 24-hour value (0..23) onto the 12-hour dial (1..12).
    // Midnight and noon both read 12; the pm output tells them apart.
    function automatic logic [4:0] hr_to_12h(input logic [4:0] hr24);
        logic [4:0] hr12;
        if (hr24 == 5'd0) begin
            hr12 = 5'd12;
        end else if (hr24 > 5'd12) begin
            hr12 = hr24 - 5'd12;
        end else begin
            hr12 = hr24;
        end
        return hr12;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_mod_counter.sv
// Wrapping modulo counter, 0..MAX, used for the seconds, minutes and hours
// fields. wrap flags the increment that takes the counter from MAX back to 0
// so the caller can decide whether that carries into the next field.
module mod_counter
    import rtc_pkg::*;
#(
    parameter int MAX = 59,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic at_max_s;

    assign at_max_s = (value == W'(MAX));
    assign wrap     = at_max_s & inc;

    // Field register: synchronous clear dominates, otherwise count and wrap at MAX
    always_ff @(posedge clk) begin
        if (clr) begin
            value <= {W{1'b0}};
        end else if (inc) begin
            if (at_max_s) begin
                value <= {W{1'b0}};
            end else begin
                value <= value + W'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Timekeeping core: on-chip 1 Hz prescaler driving a sec/min/hr cascade,
// per-field set mode, 12/24-hour display mux and a sticky hh:mm alarm.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int FIELD_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [1:0]         set_sel,
    input  logic               set_inc,
    input  logic               mode_12h,
    input  logic               disp_sel,
    input  logic               alarm_we,
    input  logic [FIELD_W-1:0] alarm_hh,
    input  logic [FIELD_W-1:0] alarm_mm,
    input  logic               alarm_on,
    input  logic               alarm_clr,
    output logic [FIELD_W-1:0] disp_hi,
    output logic [FIELD_W-1:0] disp_lo,
    output logic               pm,
    output logic               tick_1hz,
    output logic               day_wrap,
    output logic               alarm
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    // Prescaler
    logic [PW-1:0]      presc_r;
    logic               counting_s;
    logic               tick_s;

    // Field adjustment strobes
    logic               set_sec_s;
    logic               set_min_s;
    logic               set_hr_s;

    // Cascade
    logic               sec_inc_s;
    logic               min_inc_s;
    logic               hr_inc_s;
    logic [FIELD_W-1:0] sec_r;
    logic [FIELD_W-1:0] min_r;
    logic [FIELD_W-1:0] hr_r;
    logic               sec_wrap_s;
    logic               min_wrap_s;
    logic               hr_wrap_s;
    logic               day_wrap_s;

    // Registered pulses and alarm state
    logic               tick_1hz_r;
    logic               day_wrap_r;
    logic               alarm_r;
    logic [FIELD_W-1:0] alarm_hh_r;
    logic [FIELD_W-1:0] alarm_mm_r;
    logic               alarm_wr_ok_s;
    logic [FIELD_W-1:0] next_min_s;
    logic [FIELD_W-1:0] next_hr_s;
    logic               alarm_set_s;

    // Display
    logic [4:0]         hr12_s;
    logic [FIELD_W-1:0] hr_disp_s;

    // ------------------------------------------------------------------
    // Prescaler: counts only in normal mode with run high, so leaving set
    // mode always restarts a full second before the next tick.
    // ------------------------------------------------------------------
    assign counting_s = run && (set_sel == SEL_NONE);
    assign tick_s     = counting_s && (presc_r == PW'(TICK_DIV - 1));

    // Prescaler register: held at 0 while not counting, wraps on the tick
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {PW{1'b0}};
        end else if (!counting_s || tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Cascade. Manual increments act on one field only: carries are gated
    // by tick_s, which can never be high while set_sel selects a field.
    // ------------------------------------------------------------------
    assign set_sec_s = set_inc && (set_sel == SEL_SEC);
    assign set_min_s = set_inc && (set_sel == SEL_MIN);
    assign set_hr_s  = set_inc && (set_sel == SEL_HR);

    assign sec_inc_s  = tick_s | set_sec_s;
    assign min_inc_s  = (tick_s & sec_wrap_s) | set_min_s;
    assign hr_inc_s   = (tick_s & sec_wrap_s & min_wrap_s) | set_hr_s;
    assign day_wrap_s = tick_s & sec_wrap_s & min_wrap_s & hr_wrap_s;

    mod_counter #(.MAX(SEC_MAX), .W(FIELD_W)) u_sec (
        .clk   (clk),
        .clr   (rst),
        .inc   (sec_inc_s),
        .value (sec_r),
        .wrap  (sec_wrap_s)
    );

    mod_counter #(.MAX(MIN_MAX), .W(FIELD_W)) u_min (
        .clk   (clk),
        .clr   (rst),
        .inc   (min_inc_s),
        .value (min_r),
        .wrap  (min_wrap_s)
    );

    mod_counter #(.MAX(HR_MAX), .W(FIELD_W)) u_hr (
        .clk   (clk),
        .clr   (rst),
        .inc   (hr_inc_s),
        .value (hr_r),
        .wrap  (hr_wrap_s)
    );

    // One-cycle pulses, registered so they line up with the updated fields
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_1hz_r <= 1'b0;
            day_wrap_r <= 1'b0;
        end else begin
            tick_1hz_r <= tick_s;
            day_wrap_r <= day_wrap_s;
        end
    end

    // ------------------------------------------------------------------
    // Alarm
    // ------------------------------------------------------------------
    assign alarm_wr_ok_s = alarm_we
                        && (alarm_hh <= FIELD_W'(HR_MAX))
                        && (alarm_mm <= FIELD_W'(MIN_MAX));

    // Alarm time registers: out-of-range writes leave the old setting intact
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hh_r <= {FIELD_W{1'b0}};
            alarm_mm_r <= {FIELD_W{1'b0}};
        end else if (alarm_wr_ok_s) begin
            alarm_hh_r <= alarm_hh;
            alarm_mm_r <= alarm_mm;
        end
    end

    // hr:min the cascade will hold after a tick that wraps seconds to 0
    always_comb begin
        next_min_s = min_r;
        next_hr_s  = hr_r;
        if (min_wrap_s) begin
            next_min_s = {FIELD_W{1'b0}};
            if (hr_wrap_s) begin
                next_hr_s = {FIELD_W{1'b0}};
            end else begin
                next_hr_s = hr_r + FIELD_W'(1);
            end
        end else begin
            next_min_s = min_r + FIELD_W'(1);
            next_hr_s  = hr_r;
        end
    end

    // Only a real timekeeping tick landing on hh:mm:00 can fire the alarm
    assign alarm_set_s = alarm_on && tick_s && sec_wrap_s
                      && (next_hr_s == alarm_hh_r)
                      && (next_min_s == alarm_mm_r);

    // Sticky alarm flag: a fresh match beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_r <= 1'b0;
        end else if (alarm_set_s) begin
            alarm_r <= 1'b1;
        end else if (alarm_clr) begin
            alarm_r <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display mux, combinational from the field registers
    // ------------------------------------------------------------------
    assign hr12_s = hr_to_12h(hr_r[4:0]);

    // Select 12h or 24h hour presentation
    always_comb begin
        hr_disp_s = hr_r;
        if (mode_12h) begin
            hr_disp_s = {{(FIELD_W - 5){1'b0}}, hr12_s};
        end else begin
            hr_disp_s = hr_r;
        end
    end

    assign disp_hi  = disp_sel ? hr_disp_s : min_r;
    assign disp_lo  = disp_sel ? min_r     : sec_r;
    assign pm       = (hr_r >= FIELD_W'(12));
    assign tick_1hz = tick_1hz_r;
    assign day_wrap = day_wrap_r;
    assign alarm    = alarm_r;

endmodule
